// File: rtl/mux7_rr_arbiter_if.sv
// Handshake/bus bundle for mux7_rr_arbiter: requests, flat source data, grant pulses
// and the registered output word with its valid/ready handshake.
interface mux7_rr_arbiter_if #(
  parameter int N_REQ  = 7,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        gnt;
  logic [SEL_W-1:0]        selector;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  // Arbiter side
  modport master (
    input  req, data_in, out_ready,
    output gnt, selector, out_data, out_valid, busy
  );

  // Sources/consumer side
  modport slave (
    output req, data_in, out_ready,
    input  gnt, selector, out_data, out_valid, busy
  );
endinterface

// File: rtl/mux7_rr_arbiter.sv
// Round-robin arbiter sharing one 7-input, 32-bit mux path. Captures the winning
// source's word into an output register and holds it under valid/ready until accepted.
module mux7_rr_arbiter #(
  parameter int N_REQ  = 7,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mux7_rr_arbiter_if.master  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    last;
  logic [SEL_W-1:0]    win;
  logic [SEL_W-1:0]    idx;
  logic                win_found;
  logic                capture;
  logic                accept;
  logic [DATA_W-1:0]   src [N_REQ];
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic [N_REQ-1:0]    gnt_q;

  // Split the flat source bus into per-source words
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      src[i] = bus.data_in[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan starting just after the last winner, so it gets lowest priority
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = SEL_W'((32'(last) + k) % N_REQ);
      if (!win_found && bus.req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: capture on any request in IDLE, release on handshake in BUSY
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          capture   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (valid_q && bus.out_ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, grant pulse and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
      last    <= SEL_W'(N_REQ - 1);
    end else begin
      gnt_q <= '0;
      if (capture) begin
        sel_q   <= win;
        data_q  <= src[win];
        valid_q <= 1'b1;
        gnt_q   <= N_REQ'(1) << win;
      end
      if (accept) begin
        valid_q <= 1'b0;
        last    <= sel_q;
      end
    end
  end

  // Drive interface outputs
  always_comb begin
    bus.gnt       = gnt_q;
    bus.selector  = sel_q;
    bus.out_data  = data_q;
    bus.out_valid = valid_q;
    bus.busy      = (state == BUSY);
  end

endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// Directed self-checking bench for mux7_rr_arbiter.
module tb_mux7_rr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  mux7_rr_arbiter_if #(.N_REQ(7), .SEL_W(3), .DATA_W(32)) bus ();

  mux7_rr_arbiter #(.N_REQ(7), .SEL_W(3), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int unsigned i, input logic [31:0] v);
    bus.data_in[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.req       = '0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    tick();

    // Reset state
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_gnt",   32'(bus.gnt),       32'd0);
    chk("rst_sel",   32'(bus.selector),  32'd0);
    chk("rst_data",  bus.out_data,       32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    reset = 1'b0;

    // 1: single capture held under backpressure
    set_data(0, 32'hDEADBEEF);
    bus.req = 7'b0000001;
    tick();
    chk("t1_gnt",   32'(bus.gnt),       32'h01);
    chk("t1_sel",   32'(bus.selector),  32'd0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data",  bus.out_data,       32'hDEADBEEF);
    chk("t1_busy",  32'(bus.busy),      32'd1);
    bus.req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_hold_gnt",   32'(bus.gnt),       32'h00);
      chk("t1_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_hold_data",  bus.out_data,       32'hDEADBEEF);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t1_acc_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_acc_busy",  32'(bus.busy),      32'd0);

    // 2: all requesting from reset, order 0..6, one grant every 2 cycles
    do_reset();
    for (int unsigned i = 0; i < 7; i++) set_data(i, 32'h10000000 + i);
    bus.req = 7'h7F;
    for (int unsigned k = 0; k < 7; k++) begin
      tick();
      chk("t2_gnt",  32'(bus.gnt),      32'd1 << k);
      chk("t2_sel",  32'(bus.selector), k);
      chk("t2_data", bus.out_data,      32'h10000000 + k);
      bus.req[k] = 1'b0;
      tick();
      chk("t2_gap_gnt",   32'(bus.gnt),       32'd0);
      chk("t2_gap_valid", 32'(bus.out_valid), 32'd0);
    end

    // 3: wrap-around, after source 5 source 6 beats source 0
    do_reset();
    bus.req = 7'b0100000;
    tick();
    chk("t3_gnt5", 32'(bus.gnt), 32'h20);
    bus.req = 7'b1000001;
    tick();
    chk("t3_acc5", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t3_gnt6", 32'(bus.gnt),      32'h40);
    chk("t3_sel6", 32'(bus.selector), 32'd6);
    bus.req = 7'b0000001;
    tick();
    tick();
    chk("t3_gnt0", 32'(bus.gnt),      32'h01);
    chk("t3_sel0", 32'(bus.selector), 32'd0);
    bus.req = '0;
    tick();

    // 4: backpressure, data and requests changing while held
    bus.out_ready = 1'b0;
    set_data(2, 32'hAAAA0002);
    bus.req = 7'b0000100;
    tick();
    chk("t4_gnt2", 32'(bus.gnt), 32'h04);
    bus.req = 7'b0001000;
    for (int unsigned i = 0; i < 7; i++) set_data(i, 32'h55550000 + i);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_data",  bus.out_data,       32'hAAAA0002);
      chk("t4_hold_sel",   32'(bus.selector),  32'd2);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_gnt",   32'(bus.gnt),       32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_acc_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t4_gnt3",  32'(bus.gnt),      32'h08);
    chk("t4_sel3",  32'(bus.selector), 32'd3);
    chk("t4_data3", bus.out_data,      32'h55550003);
    bus.req = '0;
    tick();

    // 5: asynchronous reset while BUSY
    bus.out_ready = 1'b0;
    bus.req = 7'b0010000;
    tick();
    chk("t5_busy", 32'(bus.busy), 32'd1);
    bus.req = '0;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_busy0", 32'(bus.busy),      32'd0);
    chk("t5_sel",   32'(bus.selector),  32'd0);
    chk("t5_gnt",   32'(bus.gnt),       32'd0);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    bus.req = 7'h7F;
    tick();
    chk("t5_gnt0",  32'(bus.gnt),  32'h01);
    chk("t5_data0", bus.out_data,  32'h55550000);
    bus.req = '0;
    tick();

    // 6: idle with no requests, captured word and selector hold
    set_data(0, 32'h12345678);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_gnt",   32'(bus.gnt),       32'd0);
      chk("t6_busy",  32'(bus.busy),      32'd0);
      chk("t6_sel",   32'(bus.selector),  32'd0);
      chk("t6_data",  bus.out_data,       32'h55550000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
